// File: rtl/bin_to_bcd_display_if.sv
// Request/result and display-pin bundle for bin_to_bcd_display.
// master = the block requesting conversions, slave = the converter itself.
interface bin_to_bcd_display_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;

    modport master (
        output start, bin_in,
        input  busy, done, ovf, bcd_out, seg, an
    );

    modport slave (
        input  start, bin_in,
        output busy, done, ovf, bcd_out, seg, an
    );
endinterface

// File: rtl/bin_to_bcd_display.sv
// Iterative double-dabble binary-to-BCD converter with a multiplexed common-anode 7-seg scanner.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (never digit 0, never on overflow).
module bin_to_bcd_display #(
    parameter int BIN_W    = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bin_to_bcd_display_if.slave  bus
);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t             r_state, w_next_state;
    logic [BIN_W-1:0]   r_bin;
    logic [BCD_W-1:0]   r_scratch;
    logic [BCD_W-1:0]   w_adj;
    logic               r_sticky;
    logic [CNT_W-1:0]   r_shift_cnt;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ovf;
    logic               r_done;

    logic [SCAN_W-1:0]  r_scan_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [3:0]         w_digit;
    logic [DIGITS-1:0]  w_an;
    logic               w_blank;
    logic [6:0]         r_seg;
    logic [DIGITS-1:0]  r_an;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: combinational blocks assign defaults first so no path leaves a signal unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_SHIFT;
            S_SHIFT: if (r_shift_cnt == CNT_W'(BIN_W - 1)) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Add-3 correction applied to every nibble before the shift.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin       <= '0;
            r_scratch   <= '0;
            r_sticky    <= 1'b0;
            r_shift_cnt <= '0;
            r_bcd       <= '0;
            r_ovf       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_bin       <= bus.bin_in;
                        r_scratch   <= '0;
                        r_sticky    <= 1'b0;
                        r_shift_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    r_scratch   <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
                    r_bin       <= r_bin << 1;
                    r_sticky    <= r_sticky | w_adj[BCD_W-1];
                    r_shift_cnt <= r_shift_cnt + CNT_W'(1);
                end
                S_DONE: begin
                    r_bcd  <= r_scratch;
                    r_ovf  <= r_sticky;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    always_comb begin
        w_digit = 4'd0;
        w_an    = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == r_idx) begin
                w_digit = r_bcd[4*i +: 4];
                w_an[i] = 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; a digit is blank only if it and everything above it is zero.
    always_comb begin
        logic hi_nz;
        hi_nz   = 1'b0;
        w_blank = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_nz = hi_nz | (r_bcd[4*i +: 4] != 4'd0);
            if (IDX_W'(i) == r_idx) w_blank = !hi_nz && !r_ovf;
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= 7'b1111111;
            r_an  <= '1;
        end else begin
            r_seg <= w_blank ? 7'b1111111 : seg_of(w_digit);
            r_an  <= w_an;
        end
    end

    assign bus.busy    = (r_state == S_SHIFT);
    assign bus.done    = r_done;
    assign bus.ovf     = r_ovf;
    assign bus.bcd_out = r_bcd;
    assign bus.seg     = r_seg;
    assign bus.an      = r_an;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Self-checking bench: two converters (3 and 2 digits) share one stimulus stream and are
// compared every cycle against an arithmetic model, plus hand-computed literal expectations.
module tb_bin_to_bcd_display;
    localparam int BIN_W = 10;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ_ON = 1'b1;
`else
    localparam bit LZ_ON = 1'b0;
`endif
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
        7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f};

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [BIN_W-1:0] bin_in;
    int               errors = 0;
    int               checks = 0;

    bin_to_bcd_display_if #(.BIN_W(BIN_W), .DIGITS(3)) if_a ();
    bin_to_bcd_display_if #(.BIN_W(BIN_W), .DIGITS(2)) if_b ();

    assign if_a.start  = start;
    assign if_a.bin_in = bin_in;
    assign if_b.start  = start;
    assign if_b.bin_in = bin_in;

    bin_to_bcd_display #(.BIN_W(BIN_W), .DIGITS(3), .SCAN_DIV(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a));
    bin_to_bcd_display #(.BIN_W(BIN_W), .DIGITS(2), .SCAN_DIV(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v, input int d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] disp(input logic [31:0] bcd, input bit ov, input int idx);
        if (LZ_ON && idx > 0 && !ov && ((bcd >> (4*idx)) == 0)) return 7'h7f;
        return SEG_TAB[bcd[4*idx +: 4]];
    endfunction

    // Model: conversion result appears BIN_W+1 edges after the accepting edge; the display
    // shows digit floor(edges/SCAN_DIV) mod DIGITS, one edge late.
    int          m_t, m_val, m_edges;
    logic        m_busy, m_done, m_ovf_a, m_ovf_b;
    logic [31:0] m_bcd_a, m_bcd_b;
    logic [6:0]  m_seg_a, m_seg_b;
    logic [2:0]  m_an_a;
    logic [1:0]  m_an_b;

    always @(posedge clk or negedge rst_n) begin
        int nt;
        if (!rst_n) begin
            m_t <= 0; m_val <= 0; m_edges <= 0; m_busy <= 1'b0; m_done <= 1'b0;
            m_bcd_a <= '0; m_ovf_a <= 1'b0; m_bcd_b <= '0; m_ovf_b <= 1'b0;
            m_seg_a <= 7'h7f; m_an_a <= '1; m_seg_b <= 7'h7f; m_an_b <= '1;
        end else begin
            m_seg_a <= disp(m_bcd_a, m_ovf_a, (m_edges / 4) % 3);
            m_an_a  <= ~(3'b001 << ((m_edges / 4) % 3));
            m_seg_b <= disp(m_bcd_b, m_ovf_b, (m_edges / 3) % 2);
            m_an_b  <= ~(2'b01 << ((m_edges / 3) % 2));
            m_edges <= m_edges + 1;
            nt = m_t;
            m_done <= 1'b0;
            if (m_t == BIN_W + 1) begin
                m_bcd_a <= to_bcd(m_val, 3); m_ovf_a <= (m_val >= 1000);
                m_bcd_b <= to_bcd(m_val, 2); m_ovf_b <= (m_val >= 100);
                m_done  <= 1'b1;
                nt = 0;
            end else if (m_t > 0) begin
                nt = m_t + 1;
            end else if (start) begin
                nt = 1;
                m_val <= int'(bin_in);
            end
            m_t    <= nt;
            m_busy <= (nt >= 1 && nt <= BIN_W);
        end
    end

    always @(negedge clk) begin
        check("a_busy", if_a.busy, m_busy);
        check("a_done", if_a.done, m_done);
        check("a_ovf",  if_a.ovf,  m_ovf_a);
        check("a_bcd",  if_a.bcd_out, m_bcd_a);
        check("a_seg",  if_a.seg,  m_seg_a);
        check("a_an",   if_a.an,   m_an_a);
        check("b_busy", if_b.busy, m_busy);
        check("b_done", if_b.done, m_done);
        check("b_ovf",  if_b.ovf,  m_ovf_b);
        check("b_bcd",  if_b.bcd_out, m_bcd_b);
        check("b_seg",  if_b.seg,  m_seg_b);
        check("b_an",   if_b.an,   m_an_b);
        check("busy_done_overlap", if_a.busy & if_a.done, 1'b0);
    end

    // Call between edges with the DUT idle; returns during the done cycle.
    task automatic run_conv(input int val, input bit hold);
        int lat;
        lat    = 0;
        bin_in = BIN_W'(val);
        start  = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 1 && !hold) start = 1'b0;
            if (if_a.done) begin
                lat = k - 1;
                break;
            end
        end
        start = 1'b0;
        check("latency", lat, BIN_W + 1);
    endtask

    task automatic scan_check(input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2);
        logic [6:0] exp_seg [3];
        logic [2:0] exp_an  [3];
        logic [2:0] prev;
        bit         found;
        exp_seg = '{e0, e1, e2};
        exp_an  = '{3'b110, 3'b101, 3'b011};
        found   = 1'b0;
        prev    = '1;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (prev == 3'b011 && if_a.an == 3'b110) found = 1'b1;
            prev = if_a.an;
        end
        check("scan_align", found, 1'b1);
        for (int j = 0; j < 16; j++) begin
            check("scan_an",  if_a.an,  exp_an[(j / 4) % 3]);
            check("scan_seg", if_a.seg, exp_seg[(j / 4) % 3]);
            @(negedge clk);
        end
    endtask

    initial begin
        int ndone;
        int pick;
        start  = 1'b0;
        bin_in = '0;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", if_a.busy, 1'b0);
        check("rst_done", if_a.done, 1'b0);
        check("rst_bcd",  if_a.bcd_out, 12'h000);
        check("rst_seg",  if_a.seg, 7'b1111111);
        check("rst_an",   if_a.an, 3'b111);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_conv(255, 1'b0);
        check("bcd_255", if_a.bcd_out, 12'h255);
        check("ovf_255", if_a.ovf, 1'b0);
        run_conv(0, 1'b0);
        check("bcd_0", if_a.bcd_out, 12'h000);
        run_conv(99, 1'b0);
        check("bcd_99", if_a.bcd_out, 12'h099);
        run_conv(123, 1'b0);
        check("b_bcd_123", if_b.bcd_out, 8'h23);
        check("b_ovf_123", if_b.ovf, 1'b1);
        run_conv(45, 1'b0);
        check("b_bcd_45", if_b.bcd_out, 8'h45);
        check("b_ovf_45", if_b.ovf, 1'b0);

        run_conv(200, 1'b1);
        check("bcd_200", if_a.bcd_out, 12'h200);
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (if_a.done) ndone++;
        end
        check("hold_single_done", ndone, 0);

        bin_in = BIN_W'(300);
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", if_a.busy, 1'b0);
        check("abort_bcd",  if_a.bcd_out, 12'h000);
        check("abort_seg",  if_a.seg, 7'b1111111);
        check("abort_an",   if_a.an, 3'b111);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_conv(17, 1'b0);
        check("bcd_17", if_a.bcd_out, 12'h017);

        run_conv(507, 1'b0);
        scan_check(7'b1111000, 7'b1000000, 7'b0010010);
        run_conv(7, 1'b0);
        scan_check(7'b1111000, LZ_ON ? 7'b1111111 : 7'b1000000, LZ_ON ? 7'b1111111 : 7'b1000000);
        run_conv(0, 1'b0);
        scan_check(7'b1000000, LZ_ON ? 7'b1111111 : 7'b1000000, LZ_ON ? 7'b1111111 : 7'b1000000);
        run_conv(1005, 1'b0);
        check("a_ovf_1005", if_a.ovf, 1'b1);
        scan_check(7'b0010010, 7'b1000000, 7'b1000000);

        // Random traffic, including starts that land while a conversion is running.
        for (int n = 0; n < 150; n++) begin
            pick   = $urandom_range(0, 9);
            bin_in = (pick == 0) ? BIN_W'(999) : (pick == 1) ? BIN_W'(1000) :
                     (pick == 2) ? BIN_W'(1023) : BIN_W'($urandom_range(0, 1023));
            start  = 1'b1;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            start = 1'b0;
            repeat ($urandom_range(0, 15)) @(posedge clk);
            #1;
        end
        repeat (20) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
